// File: rtl/pc_lut_prog_if.sv
// Bus bundle for the programmable PC target table: read port, direct
// write port, invalidate, and the streaming program loader.
//
// Handshake: a loader beat transfers on every rising edge where both
// ld_valid and ld_ready are high. ld_valid may be raised without waiting
// for ld_ready, and ld_data must stay stable while ld_valid is high and
// ld_ready is low. ld_ready never depends combinationally on ld_valid.
// rd_en and wr_en are single-cycle requests with no backpressure.
interface pc_lut_prog_if #(
   parameter int IDX_W = 5,
   parameter int VAL_W = 16
);
   logic             rd_en;
   logic [IDX_W-1:0] index;
   logic [VAL_W-1:0] value;
   logic             hit;
   logic             rd_valid;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [VAL_W-1:0] wr_data;
   logic             wr_drop;
   logic             clear;
   logic             ld_start;
   logic [IDX_W-1:0] ld_base;
   logic [IDX_W:0]   ld_count;
   logic             ld_valid;
   logic [VAL_W-1:0] ld_data;
   logic             ld_ready;
   logic             ld_busy;
   logic             ld_done;
   logic [1:0]       dbg_state;

   modport master (
      output rd_en, index, wr_en, wr_idx, wr_data, clear,
             ld_start, ld_base, ld_count, ld_valid, ld_data,
      input  value, hit, rd_valid, wr_drop, ld_ready, ld_busy, ld_done,
             dbg_state
   );

   modport slave (
      input  rd_en, index, wr_en, wr_idx, wr_data, clear,
             ld_start, ld_base, ld_count, ld_valid, ld_data,
      output value, hit, rd_valid, wr_drop, ld_ready, ld_busy, ld_done,
             dbg_state
   );
endinterface

// File: rtl/pc_lut_prog.sv
// Runtime-programmable branch/jump target table. Entries carry a valid bit
// so unprogrammed indices read back with hit=0. Entries are written either
// one at a time or by a streaming loader that walks from a base index with
// wraparound. Reads are registered with write-first bypass.
module pc_lut_prog #(
   parameter int IDX_W = 5,
   parameter int VAL_W = 16
) (
   input  logic         Clk,
   input  logic         Reset_n,
   pc_lut_prog_if.slave bus
);
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] ONE_CNT   = (IDX_W+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   rem_q, rem_d;
   logic [VAL_W-1:0] mem_q [DEPTH];
   logic [VAL_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [VAL_W-1:0] value_q, value_d;
   logic             hit_q, hit_d;
   logic             rd_valid_q, rd_valid_d;
   logic             ld_ready_q, ld_ready_d;
   logic             ld_busy_q, ld_busy_d;
   logic             ld_done_q, ld_done_d;

   logic             dir_we, ld_we, we;
   logic [IDX_W-1:0] w_idx;
   logic [VAL_W-1:0] w_data;
   logic [IDX_W:0]   cnt_clamped;

   // Select the single write that can commit this cycle (direct writes only
   // happen in IDLE, loader beats only in LOAD, so they never collide).
   always_comb begin
      dir_we      = bus.wr_en && !ld_busy_q;
      ld_we       = ld_ready_q && bus.ld_valid;
      we          = dir_we || ld_we;
      w_idx       = dir_we ? bus.wr_idx : ptr_q;
      w_data      = dir_we ? bus.wr_data : bus.ld_data;
      cnt_clamped = (bus.ld_count > DEPTH_CNT) ? DEPTH_CNT : bus.ld_count;
   end

   // Next table contents: clear drops all valid bits, a same-cycle write wins.
   always_comb begin
      mem_d = mem_q;
      vld_d = bus.clear ? '0 : vld_q;
      if (we) begin
         mem_d[w_idx] = w_data;
         vld_d[w_idx] = 1'b1;
      end
   end

   // Read response; a write landing on the read index is forwarded.
   always_comb begin
      rd_valid_d = bus.rd_en;
      value_d    = value_q;
      hit_d      = hit_q;
      if (bus.rd_en) begin
         if (we && (w_idx == bus.index)) begin
            value_d = w_data;
            hit_d   = 1'b1;
         end else if (vld_q[bus.index]) begin
            value_d = mem_q[bus.index];
            hit_d   = 1'b1;
         end else begin
            value_d = '0;
            hit_d   = 1'b0;
         end
      end
   end

   // Loader sequencing and its registered status outputs.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ld_start) begin
               ptr_d   = bus.ld_base;
               rem_d   = cnt_clamped;
               state_d = (cnt_clamped == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (ld_we) begin
               ptr_d = ptr_q + 1'b1;
               rem_d = rem_q - ONE_CNT;
               if (rem_q == ONE_CNT) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ld_ready_d = (state_d == S_LOAD);
      ld_busy_d  = (state_d != S_IDLE);
      ld_done_d  = (state_d == S_DONE);
   end

   // All state; an asynchronous reset wipes the table and aborts any load.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         rem_q      <= '0;
         mem_q      <= '{default: '0};
         vld_q      <= '0;
         value_q    <= '0;
         hit_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         ld_ready_q <= 1'b0;
         ld_busy_q  <= 1'b0;
         ld_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         mem_q      <= mem_d;
         vld_q      <= vld_d;
         value_q    <= value_d;
         hit_q      <= hit_d;
         rd_valid_q <= rd_valid_d;
         ld_ready_q <= ld_ready_d;
         ld_busy_q  <= ld_busy_d;
         ld_done_q  <= ld_done_d;
      end
   end

   assign bus.value     = value_q;
   assign bus.hit       = hit_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.wr_drop   = bus.wr_en && ld_busy_q;
   assign bus.ld_ready  = ld_ready_q;
   assign bus.ld_busy   = ld_busy_q;
   assign bus.ld_done   = ld_done_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_pc_lut_prog.sv
// Bench for pc_lut_prog: directed scenarios followed by random traffic,
// all checked against a table-level reference model through a scoreboard.
module tb_pc_lut_prog;
   localparam int IDX_W = 5;
   localparam int VAL_W = 16;
   localparam int DEPTH = 32;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   pc_lut_prog_if #(.IDX_W(IDX_W), .VAL_W(VAL_W)) bus ();
   pc_lut_prog #(.IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .bus    (bus)
   );

   // ---------------- scoreboard ----------------
   logic [VAL_W:0] exp_q[$];   // {hit, value} for each issued read
   logic [4:0]     ctl_q[$];   // {rd_valid, wr_drop, ld_ready, ld_busy, ld_done} per cycle
   int n_checks = 0;
   int n_errors = 0;
   bit mon_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned m_mem[DEPTH];
   bit          m_vld[DEPTH];
   bit          m_loading, m_finishing, m_prev_rd;
   int          m_ptr, m_rem;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = 0;
         m_vld[i] = 0;
      end
      m_loading = 0; m_finishing = 0; m_prev_rd = 0;
      m_ptr = 0; m_rem = 0;
   endtask

   // Applies this cycle's driven inputs to the model and records what the
   // DUT must show now (status) and next cycle (read data).
   task automatic model_cycle();
      bit busy, do_w;
      int wi, ri, cnt;
      int unsigned wd;
      busy = m_loading || m_finishing;
      ctl_q.push_back({m_prev_rd, bus.wr_en && busy, m_loading, busy, m_finishing});
      do_w = 0; wi = 0; wd = 0;
      if (bus.wr_en && !busy) begin
         do_w = 1; wi = int'(bus.wr_idx); wd = bus.wr_data;
      end else if (m_loading && bus.ld_valid) begin
         do_w = 1; wi = m_ptr; wd = bus.ld_data;
      end
      if (bus.rd_en) begin
         ri = int'(bus.index);
         if (do_w && wi == ri)  exp_q.push_back({1'b1, VAL_W'(wd)});
         else if (m_vld[ri])    exp_q.push_back({1'b1, VAL_W'(m_mem[ri])});
         else                   exp_q.push_back('0);
      end
      if (bus.clear) for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
      if (do_w) begin
         m_mem[wi] = wd;
         m_vld[wi] = 1;
      end
      m_prev_rd = bus.rd_en;
      if (m_finishing) begin
         m_finishing = 0;
      end else if (m_loading) begin
         if (bus.ld_valid) begin
            m_ptr = (m_ptr + 1) % DEPTH;
            m_rem--;
            if (m_rem == 0) begin
               m_loading = 0; m_finishing = 1;
            end
         end
      end else if (bus.ld_start) begin
         cnt   = int'(bus.ld_count);
         m_ptr = int'(bus.ld_base);
         m_rem = (cnt > DEPTH) ? DEPTH : cnt;
         if (m_rem == 0) m_finishing = 1;
         else            m_loading = 1;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge Clk) begin
      logic [4:0]     c;
      logic [VAL_W:0] e;
      if (mon_en) begin
         if (ctl_q.size() == 0) begin
            chk("ctl_underflow", 1, 0);
         end else begin
            c = ctl_q.pop_front();
            chk("rd_valid", bus.rd_valid, c[4]);
            chk("wr_drop",  bus.wr_drop,  c[3]);
            chk("ld_ready", bus.ld_ready, c[2]);
            chk("ld_busy",  bus.ld_busy,  c[1]);
            chk("ld_done",  bus.ld_done,  c[0]);
            if (c[4]) begin
               if (exp_q.size() == 0) begin
                  chk("exp_underflow", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.rd_valid) begin
                     chk("rd_value", bus.value, e[VAL_W-1:0]);
                     chk("rd_hit",   bus.hit,   e[VAL_W]);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.rd_en = 0; bus.index = '0;
      bus.wr_en = 0; bus.wr_idx = '0; bus.wr_data = '0;
      bus.clear = 0;
      bus.ld_start = 0; bus.ld_base = '0; bus.ld_count = '0;
      bus.ld_valid = 0; bus.ld_data = '0;
   endtask

   task automatic tick();
      model_cycle();
      @(posedge Clk);
      #1;
      idle_inputs();
   endtask

   task automatic do_read(input int idx);
      bus.rd_en = 1; bus.index = IDX_W'(idx);
      tick();
   endtask

   task automatic do_write(input int idx, input int unsigned data);
      bus.wr_en = 1; bus.wr_idx = IDX_W'(idx); bus.wr_data = VAL_W'(data);
      tick();
   endtask

   task automatic do_ld_start(input int base, input int cnt);
      bus.ld_start = 1; bus.ld_base = IDX_W'(base); bus.ld_count = (IDX_W+1)'(cnt);
      tick();
   endtask

   task automatic do_beat(input int unsigned data);
      bus.ld_valid = 1; bus.ld_data = VAL_W'(data);
      tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_value"},    bus.value,    0);
      chk({tag, "_hit"},      bus.hit,      0);
      chk({tag, "_rd_valid"}, bus.rd_valid, 0);
      chk({tag, "_wr_drop"},  bus.wr_drop,  0);
      chk({tag, "_ld_ready"}, bus.ld_ready, 0);
      chk({tag, "_ld_busy"},  bus.ld_busy,  0);
      chk({tag, "_ld_done"},  bus.ld_done,  0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      model_reset();
      Reset_n = 1'b1;
      #1 Reset_n = 1'b0;
      #2 check_outputs_zero("reset");
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      mon_en = 1;

      // Empty table: every read misses with value 0.
      for (int i = 0; i < DEPTH; i++) do_read(i);
      tick();

      // Direct writes and reads, including a miss.
      do_write(25, 16'hFE00);
      do_write(5, 72);
      do_read(25);
      do_read(5);
      do_read(6);
      tick();

      // Wrapping load with a stall, plus a dropped direct write.
      do_ld_start(30, 4);
      do_beat(100);
      do_beat(101);
      tick();
      tick();
      bus.wr_en = 1; bus.wr_idx = 5'd0; bus.wr_data = 16'd555;
      do_beat(102);
      do_beat(103);
      tick();
      tick();
      do_read(30); do_read(31); do_read(0); do_read(1); do_read(5);
      tick();

      // Zero-length load, then a full-table load wrapping from base 7.
      do_ld_start(3, 0);
      tick(); tick();
      do_ld_start(7, 32);
      for (int i = 0; i < DEPTH; i++) do_beat($urandom_range(0, 16'hFFFF));
      tick(); tick();
      for (int i = 0; i < DEPTH; i++) do_read(i);
      tick();

      // Oversized count is clamped to a full table.
      do_ld_start(0, 40);
      for (int i = 0; i < DEPTH + 3; i++) do_beat(1000 + i);
      tick();

      // Same-cycle write/read bypass, then clear racing a write.
      bus.rd_en = 1; bus.index = 5'd3;
      do_write(3, 7);
      tick();
      bus.clear = 1; bus.rd_en = 1; bus.index = 5'd9;
      do_write(4, 9);
      for (int i = 0; i < DEPTH; i++) do_read(i);
      tick();

      // Load started alongside a direct write; clear mid-load.
      bus.wr_en = 1; bus.wr_idx = 5'd20; bus.wr_data = 16'h1234;
      do_ld_start(12, 4);
      do_beat(11); do_beat(22);
      bus.clear = 1;
      do_beat(33); do_beat(44);
      tick(); tick();
      for (int i = 10; i < 22; i++) do_read(i);
      tick();

      // Asynchronous reset in the middle of a load.
      do_ld_start(10, 5);
      do_beat(500);
      do_beat(501);
      mon_en = 0;
      Reset_n = 1'b0;
      #1 check_outputs_zero("midload_reset");
      ctl_q.delete();
      exp_q.delete();
      model_reset();
      @(posedge Clk); @(posedge Clk); #1;
      Reset_n = 1'b1;
      mon_en = 1;
      do_read(10); do_read(11);
      for (int i = 0; i < 5; i++) tick();

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         bus.rd_en    = ($urandom_range(0, 1) == 1);
         bus.index    = IDX_W'($urandom_range(0, DEPTH - 1));
         bus.wr_en    = ($urandom_range(0, 3) == 0);
         bus.wr_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
         bus.wr_data  = VAL_W'($urandom_range(0, 16'hFFFF));
         bus.clear    = ($urandom_range(0, 39) == 0);
         bus.ld_start = ($urandom_range(0, 19) == 0);
         bus.ld_base  = IDX_W'($urandom_range(0, DEPTH - 1));
         bus.ld_count = (IDX_W+1)'($urandom_range(0, 2 * DEPTH - 1));
         bus.ld_valid = ($urandom_range(0, 3) != 0);
         bus.ld_data  = VAL_W'($urandom_range(0, 16'hFFFF));
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         bus.ld_valid = 1;
         bus.ld_data  = VAL_W'(i);
         tick();
      end
      for (int i = 0; i < DEPTH; i++) do_read(i);
      tick(); tick();
      chk("exp_q_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
